// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, multi-cycle handshake,
// hazard-unit pending bitmap and the shared WE/WR/WD port.
interface regfile_write_arbiter_if;
    logic        p_we;
    logic [2:0]  p_wr;
    logic [15:0] p_wd;
    logic        m_valid;
    logic [2:0]  m_wr;
    logic [15:0] m_wd;
    logic        m_ready;
    logic        p_stall;
    logic [7:0]  pending;
    logic        WE;
    logic [2:0]  WR;
    logic [15:0] WD;

    modport slave (
        input  p_we, p_wr, p_wd, m_valid, m_wr, m_wd,
        output m_ready, p_stall, pending, WE, WR, WD
    );

    modport master (
        output p_we, p_wr, p_wd, m_valid, m_wr, m_wd,
        input  m_ready, p_stall, pending, WE, WR, WD
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and a
// 2-entry queue fed by the multi-cycle unit, with a starvation-breaking stall.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    regfile_write_arbiter_if.slave        bus
);

    logic [2:0]  wr_q [2];
    logic [15:0] wd_q [2];
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        p_stall_q, p_stall_d;

    logic        pw, ready, push, pop, blocked, tail;
    logic [7:0]  pend;

    always_comb begin
        pw      = bus.p_we && !p_stall_q;
        ready   = (count_q != 2'd2);
        push    = bus.m_valid && ready;
        pop     = !pw && (count_q != 2'd0);
        blocked = pw && (count_q != 2'd0);
        tail    = head_q ^ count_q[0];

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d = pop ? ~head_q : head_q;

        // The stall pulse frees the port for exactly one cycle so the head drains.
        if (blocked && (cnt_q == 4'(STARVE_LIMIT - 1))) begin
            cnt_d     = '0;
            p_stall_d = 1'b1;
        end else if (blocked) begin
            cnt_d     = cnt_q + 4'd1;
            p_stall_d = 1'b0;
        end else begin
            cnt_d     = '0;
            p_stall_d = 1'b0;
        end

        pend = '0;
        if (count_q != 2'd0) pend[wr_q[head_q]]  = 1'b1;
        if (count_q == 2'd2) pend[wr_q[~head_q]] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q   <= '0;
            head_q    <= 1'b0;
            cnt_q     <= '0;
            p_stall_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            cnt_q     <= cnt_d;
            p_stall_q <= p_stall_d;
        end
    end

    // Payload storage needs no reset; validity is carried by count_q alone.
    always_ff @(posedge clock) begin
        if (push) begin
            wr_q[tail] <= bus.m_wr;
            wd_q[tail] <= bus.m_wd;
        end
    end

    assign bus.m_ready = ready;
    assign bus.p_stall = p_stall_q;
    assign bus.pending = pend;
    assign bus.WE      = pw || (count_q != 2'd0);
    assign bus.WR      = pw ? bus.p_wr : ((count_q != 2'd0) ? wr_q[head_q] : '0);
    assign bus.WD      = pw ? bus.p_wd : ((count_q != 2'd0) ? wd_q[head_q] : '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a register-file model.
module tb_regfile_write_arbiter;

    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   writes14 = 0;
    int   base14;
    logic [15:0] rf [8];

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.WE === 1'b1) begin
            rf[bus.WR] <= bus.WD;
            if (bus.WR == 3'd1 || bus.WR == 3'd4) writes14 <= writes14 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_p(input logic we, input logic [2:0] wr, input logic [15:0] wd);
        bus.p_we = we;
        bus.p_wr = wr;
        bus.p_wd = wd;
    endtask

    task automatic set_m(input logic v, input logic [2:0] wr, input logic [15:0] wd);
        bus.m_valid = v;
        bus.m_wr    = wr;
        bus.m_wd    = wd;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [2:0] wr, input logic [15:0] wd);
        check({tag, "_we"}, 32'(bus.WE), 32'(we));
        check({tag, "_wr"}, 32'(bus.WR), 32'(wr));
        check({tag, "_wd"}, 32'(bus.WD), 32'(wd));
    endtask

    initial begin
        // Reset with both producers active
        reset_n = 1'b0;
        set_p(1'b1, 3'd0, 16'h0000);
        set_m(1'b1, 3'd6, 16'h0666);
        cyc(); cyc(); cyc();
        settle();
        check("rst_we_follows_p", 32'(bus.WE), 32'd1);
        check("rst_ready", 32'(bus.m_ready), 32'd1);
        cyc();
        reset_n = 1'b1;
        set_p(1'b0, 3'd0, 16'h0000);
        set_m(1'b0, 3'd0, 16'h0000);
        settle();
        check("rst_pending", 32'(bus.pending), 32'h00);
        check("rst_stall", 32'(bus.p_stall), 32'd0);
        check("rst_ready2", 32'(bus.m_ready), 32'd1);
        check("rst_nothing_queued", 32'(bus.WE), 32'd0);

        // Idle drain: no bypass, write next cycle
        set_m(1'b1, 3'd3, 16'h00AA);
        settle();
        check("idle_ready", 32'(bus.m_ready), 32'd1);
        check("idle_no_bypass", 32'(bus.WE), 32'd0);
        cyc();
        set_m(1'b0, 3'd0, 16'h0000);
        settle();
        chk_port("idle_drain", 1'b1, 3'd3, 16'h00AA);
        check("idle_pend", 32'(bus.pending), 32'h08);
        cyc();
        settle();
        check("idle_pend_clr", 32'(bus.pending), 32'h00);
        check("idle_we_off", 32'(bus.WE), 32'd0);
        check("idle_rf3", 32'(rf[3]), 32'h00AA);

        // Priority: pipeline wins, queue writes on first free cycle
        set_m(1'b1, 3'd5, 16'h1234);
        cyc();
        set_m(1'b0, 3'd0, 16'h0000);
        set_p(1'b1, 3'd2, 16'h0042);
        settle();
        chk_port("prio_c1", 1'b1, 3'd2, 16'h0042);
        check("prio_pend", 32'(bus.pending), 32'h20);
        cyc();
        settle();
        chk_port("prio_c2", 1'b1, 3'd2, 16'h0042);
        cyc();
        set_p(1'b0, 3'd0, 16'h0000);
        settle();
        chk_port("prio_q", 1'b1, 3'd5, 16'h1234);
        cyc();
        settle();
        check("prio_rf2", 32'(rf[2]), 32'h0042);
        check("prio_rf5", 32'(rf[5]), 32'h1234);

        // Starvation: stall on 5th blocked cycle
        set_m(1'b1, 3'd7, 16'hBEEF);
        cyc();
        set_m(1'b0, 3'd0, 16'h0000);
        set_p(1'b1, 3'd6, 16'h6666);
        for (int i = 1; i <= 4; i++) begin
            settle();
            check($sformatf("starve_nostall%0d", i), 32'(bus.p_stall), 32'd0);
            check($sformatf("starve_pwr%0d", i), 32'(bus.WR), 32'd6);
            cyc();
        end
        settle();
        check("starve_stall", 32'(bus.p_stall), 32'd1);
        chk_port("starve_drain", 1'b1, 3'd7, 16'hBEEF);
        cyc();
        settle();
        check("starve_pulse_end", 32'(bus.p_stall), 32'd0);
        chk_port("starve_after", 1'b1, 3'd6, 16'h6666);
        check("starve_pend", 32'(bus.pending), 32'h00);
        check("starve_rf7", 32'(rf[7]), 32'hBEEF);
        set_p(1'b0, 3'd0, 16'h0000);
        cyc();

        // Full queue under continuous pipeline writes
        set_p(1'b1, 3'd2, 16'h2222);
        set_m(1'b1, 3'd1, 16'h0011);
        settle();
        check("full_ready0", 32'(bus.m_ready), 32'd1);
        cyc();
        set_m(1'b1, 3'd4, 16'h0044);
        settle();
        check("full_ready1", 32'(bus.m_ready), 32'd1);
        check("full_pend1", 32'(bus.pending), 32'h02);
        cyc();
        set_m(1'b1, 3'd6, 16'h0066);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("full_noready%0d", i), 32'(bus.m_ready), 32'd0);
            check($sformatf("full_pend2_%0d", i), 32'(bus.pending), 32'h12);
            check($sformatf("full_nostall%0d", i), 32'(bus.p_stall), 32'd0);
            cyc();
        end
        settle();
        check("full_stall", 32'(bus.p_stall), 32'd1);
        check("full_ready_stall", 32'(bus.m_ready), 32'd0);
        chk_port("full_pop1", 1'b1, 3'd1, 16'h0011);
        cyc();
        set_p(1'b0, 3'd0, 16'h0000);
        settle();
        check("full_ready_back", 32'(bus.m_ready), 32'd1);
        check("full_pend_after", 32'(bus.pending), 32'h10);
        chk_port("full_pop2", 1'b1, 3'd4, 16'h0044);
        cyc();
        set_m(1'b0, 3'd0, 16'h0000);
        settle();
        check("full_pushpop_pend", 32'(bus.pending), 32'h40);
        chk_port("full_pop3", 1'b1, 3'd6, 16'h0066);
        cyc();
        settle();
        check("full_empty", 32'(bus.WE), 32'd0);
        check("full_rf1", 32'(rf[1]), 32'h0011);
        check("full_rf4", 32'(rf[4]), 32'h0044);

        // Reset mid-operation with two entries queued and cnt=2
        set_p(1'b1, 3'd2, 16'h0202);
        set_m(1'b1, 3'd1, 16'h0101);
        cyc();
        set_m(1'b1, 3'd4, 16'h0404);
        cyc();
        set_m(1'b0, 3'd0, 16'h0000);
        cyc();
        reset_n = 1'b0;
        settle();
        check("mid_pend_before", 32'(bus.pending), 32'h12);
        chk_port("mid_rst_p", 1'b1, 3'd2, 16'h0202);
        cyc();
        reset_n = 1'b1;
        base14 = writes14;
        settle();
        check("mid_pend", 32'(bus.pending), 32'h00);
        check("mid_ready", 32'(bus.m_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            settle();
            check($sformatf("mid_nostall%0d", i), 32'(bus.p_stall), 32'd0);
        end
        set_p(1'b0, 3'd0, 16'h0000);
        settle();
        check("mid_we_off", 32'(bus.WE), 32'd0);
        for (int i = 0; i < 4; i++) cyc();
        check("mid_no_w14", 32'(writes14 - base14), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8 x 16-bit register file between two producers: the pipeline writeback stage, which has priority and no backpressure, and a multi-cycle unit (multiply/divide, slow load), which hands results over a valid/ready handshake into a 2-entry queue. The block sits between writeback and the register file's WE/WR/WD inputs. It bounds starvation of the queued producer by stalling the pipeline for one cycle. It exports a pending-write bitmap to the hazard unit.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the queue head may be blocked before a stall is forced (1..15).
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous, active-low reset.
- p_we  in  1  pipeline writeback write request; ignored while p_stall=1.
- p_wr  in  3  pipeline destination register.
- p_wd  in  16  pipeline write data.
- m_valid  in  1  multi-cycle unit result valid.
- m_wr  in  3  multi-cycle destination register.
- m_wd  in  16  multi-cycle result data.
- m_ready  out  1  queue can accept; equals (count<2).
- p_stall  out  1  registered; pipeline must freeze for this cycle.
- pending  out  8  bit r = 1 when any queued entry targets register r.
- WE  out  1  register-file write enable.
- WR  out  3  register-file write address.
- WD  out  16  register-file write data.

## Operation
- Queue: 2-entry FIFO of {wr[2:0], wd[15:0]}, with a count of 0..2 and a 1-bit head pointer.
- Push: when m_valid && m_ready at a rising edge, the entry is appended.
- m_ready depends only on the registered count. A full queue refuses a push even in a cycle where it pops.
- Grant, combinational each cycle:
  - pw = p_we && !p_stall.
  - If pw: WE=1, WR=p_wr, WD=p_wd. No pop.
  - Else if count>0: WE=1, WR/WD = head entry. The head pops at the edge.
  - Else: WE=0, WR=0, WD=0.
- Push and pop in the same cycle are legal when count is 1, and count stays 1. With count=0 there is no pop, so an incoming entry is never bypassed straight to the write port.
- Starvation counter cnt, 4 bits:
  - Define blocked = (count>0 && pw).
  - If blocked and cnt==STARVE_LIMIT-1: cnt<=0 and p_stall<=1.
  - Else if blocked: cnt<=cnt+1 and p_stall<=0.
  - Otherwise: cnt<=0 and p_stall<=0.
- p_stall is therefore a one-cycle pulse. During that cycle the head is guaranteed to drain.
- pending is computed combinationally from the valid queue entries. The hazard unit must stall any reader or writer of a pending register; the arbiter itself does not order WAW writes between the two producers.
- Register 0 is an ordinary writable register: no special casing.

## Timing
- Reset (reset_n=0 at an edge): count=0, head=0, cnt=0, p_stall=0. Consequently m_ready=1, pending=0, and WE=0 unless p_we=1.
- Reset has priority over a push in the same cycle; that entry is dropped. Reset in the middle of a blocked period clears cnt and drops queued data.
- Pipeline write latency is 0: WE/WR/WD follow p_* in the same cycle, and the register file commits at that edge.
- Queued write latency is at least 1 cycle from the accepting edge. It is at most STARVE_LIMIT+1 cycles after the entry reaches the head.
- p_stall asserts in the cycle after the STARVE_LIMIT-th consecutive blocked cycle. It is high for exactly 1 cycle.
- A full queue with continuous pipeline writes drains both entries within 2*(STARVE_LIMIT+1) cycles.

## Test plan
- Reset: hold reset_n=0 with p_we=1, m_valid=1, then release. Required: count=0, m_ready=1, pending=0, p_stall=0, and nothing queued.
- Idle drain: with p_we=0, push {wr=3, wd=0x00AA}. Required: m_ready stays 1; the next cycle shows WE=1, WR=3, WD=0x00AA and pending[3]=1; the cycle after shows pending=0. A following read of register 3 returns 0x00AA.
- Priority: push {5, 0x1234}, then p_we=1 with {2, 0x0042} for 2 cycles, then p_we=0. Required: register 2 is written first and register 5 is written in the first cycle with p_we=0.
- Starvation (STARVE_LIMIT=4): queue {7, 0xBEEF}, then p_we=1 continuously. Required: p_stall=1 in the 5th cycle only; in that cycle WE=1, WR=7, WD=0xBEEF, and p_we is ignored.
- Full queue: push {1, 0x11} and {4, 0x44} back-to-back under p_we=1. Required: m_ready=0 and a third m_valid is held off. After the first pop m_ready returns to 1, and a simultaneous push/pop leaves count=1 with FIFO order preserved.
- Reset mid-operation: with 2 entries queued and cnt=2, assert reset_n=0 for one cycle. Required: pending=0, cnt=0, and no write to register 1 or 4 afterwards.
